// File: rtl/traffic_light_multi.sv
// traffic_light_multi: round-robin traffic light controller for NUM_DIR approaches.
// Each approach has a car-sensor switch (SW) and an RGB LED (R/G/B).
// Minimum green, yellow and all-red clearance intervals come from a 1 ms timebase.
// B shows the pending request of each approach.
// Optional build macro TRAFFIC_LIGHT_PWM_EN dims every LED channel with a 1 kHz, 50 % phase bit.
module traffic_light_multi #(
    parameter int CLK_PER   = 10,
    parameter int NUM_DIR   = 4,
    parameter int GREEN_MS  = 10000,
    parameter int YELLOW_MS = 3000,
    parameter int ALLRED_MS = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_DIR-1:0]         SW,
    output logic [NUM_DIR-1:0]         R,
    output logic [NUM_DIR-1:0]         G,
    output logic [NUM_DIR-1:0]         B,
    output logic [$clog2(NUM_DIR)-1:0] active_dir
);

    localparam int DIR_W = $clog2(NUM_DIR);
    localparam int TICK  = 1_000_000 / CLK_PER;
    localparam int PW    = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int MAXD0 = (GREEN_MS > YELLOW_MS) ? GREEN_MS : YELLOW_MS;
    localparam int MAXD  = (MAXD0 > ALLRED_MS) ? MAXD0 : ALLRED_MS;
    localparam int MS_W  = (MAXD > 1) ? $clog2(MAXD) : 1;

    localparam logic [PW-1:0]    PRESC_MAX   = PW'(TICK - 1);
    localparam logic [MS_W-1:0]  GREEN_LAST  = MS_W'(GREEN_MS - 1);
    localparam logic [MS_W-1:0]  YELLOW_LAST = MS_W'(YELLOW_MS - 1);
    localparam logic [MS_W-1:0]  ALLRED_LAST = MS_W'(ALLRED_MS - 1);
    localparam logic [DIR_W-1:0] DIR_LAST    = DIR_W'(NUM_DIR - 1);

    typedef enum logic [1:0] {
        S_ALL_RED    = 2'd0,
        S_GREEN_MIN  = 2'd1,
        S_GREEN_HOLD = 2'd2,
        S_YELLOW     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIR_W-1:0]   r_active;
    logic [DIR_W-1:0]   w_active_nxt;
    logic [DIR_W-1:0]   w_next_dir;
    logic               w_found;
    int                 w_idx;

    logic [NUM_DIR-1:0] r_sync0;
    logic [NUM_DIR-1:0] r_sync1;
    logic [NUM_DIR-1:0] r_sync2;
    logic [NUM_DIR-1:0] r_pending;
    logic [NUM_DIR-1:0] w_pend_set;
    logic [NUM_DIR-1:0] w_pend_clr;
    logic               w_other_req;

    logic               r_start;
    logic [PW-1:0]      r_presc;
    logic [MS_W-1:0]    r_ms;
    logic [MS_W-1:0]    w_last_ms;
    logic               w_ms_tick;
    logic               w_timed;
    logic               w_expire;
    logic               w_enter;
    logic               w_green_entry;

    logic [NUM_DIR-1:0] w_red;
    logic [NUM_DIR-1:0] w_grn;
    logic [NUM_DIR-1:0] r_R;
    logic [NUM_DIR-1:0] r_G;
    logic [NUM_DIR-1:0] r_B;

    // Run flag: holds the timebase and outputs idle for the first cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_start <= 1'b0;
        else        r_start <= 1'b1;
    end

    // Three-flop synchronizer on every asynchronous sensor input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync0 <= SW;
            r_sync1 <= r_sync0;
            r_sync2 <= r_sync1;
        end
    end

    // Interval timing: ms_tick at the last prescaler count, expiry on the last ms of the state
    always_comb begin
        w_ms_tick = r_start && (r_presc == PRESC_MAX);
        w_timed   = (r_state != S_GREEN_HOLD);
        case (r_state)
            S_ALL_RED:   w_last_ms = ALLRED_LAST;
            S_GREEN_MIN: w_last_ms = GREEN_LAST;
            S_YELLOW:    w_last_ms = YELLOW_LAST;
            default:     w_last_ms = '0;
        endcase
        w_expire = w_timed && w_ms_tick && (r_ms == w_last_ms);
    end

    // Round-robin search for the next pending approach after the active one
    always_comb begin
        w_next_dir = (r_active == DIR_LAST) ? '0 : r_active + 1'b1;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int k = 1; k < NUM_DIR; k++) begin
            w_idx = int'(r_active) + k;
            if (w_idx >= NUM_DIR) w_idx = w_idx - NUM_DIR;
            if (!w_found && r_pending[w_idx]) begin
                w_next_dir = DIR_W'(w_idx);
                w_found    = 1'b1;
            end
        end
        // An empty search keeps the current owner; the one empty ALL_RED
        // exit that can occur is right after reset, which rotates to approach 0.
        if (!w_found && r_pending[r_active]) w_next_dir = r_active;
    end

    // Request bookkeeping: which approaches other than the owner are waiting
    always_comb begin
        w_pend_set  = '0;
        w_pend_clr  = '0;
        w_other_req = 1'b0;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (r_sync2[i] &&
                !((r_active == DIR_W'(i)) &&
                  (r_state == S_GREEN_MIN || r_state == S_GREEN_HOLD)))
                w_pend_set[i] = 1'b1;
            if (w_green_entry && (w_next_dir == DIR_W'(i)))
                w_pend_clr[i] = 1'b1;
            if (r_pending[i] && (r_active != DIR_W'(i)))
                w_other_req = 1'b1;
        end
    end

    // FSM next-state and active approach selection
    always_comb begin
        w_state_nxt   = r_state;
        w_active_nxt  = r_active;
        w_enter       = 1'b0;
        w_green_entry = 1'b0;
        case (r_state)
            S_ALL_RED: begin
                if (w_expire) begin
                    w_state_nxt   = S_GREEN_MIN;
                    w_active_nxt  = w_next_dir;
                    w_enter       = 1'b1;
                    w_green_entry = 1'b1;
                end
            end
            S_GREEN_MIN: begin
                if (w_expire) begin
                    w_state_nxt = S_GREEN_HOLD;
                    w_enter     = 1'b1;
                end
            end
            S_GREEN_HOLD: begin
                if (w_other_req) begin
                    w_state_nxt = S_YELLOW;
                    w_enter     = 1'b1;
                end
            end
            S_YELLOW: begin
                if (w_expire) begin
                    w_state_nxt = S_ALL_RED;
                    w_enter     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_ALL_RED;
                w_enter     = 1'b1;
            end
        endcase
    end

    // FSM state and owning approach registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_ALL_RED;
            r_active <= DIR_LAST;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
        end
    end

    // Pending requests latch until their approach is granted; the grant clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending | w_pend_set) & ~w_pend_clr;
    end

    // Prescaler and ms counter restart on every state entry so each interval is exact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_ms    <= '0;
        end else if (w_enter) begin
            r_presc <= '0;
            r_ms    <= '0;
        end else if (r_start) begin
            if (r_presc == PRESC_MAX) begin
                r_presc <= '0;
                if (w_timed) r_ms <= r_ms + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Colour map from state and owning approach
    always_comb begin
        w_red = '0;
        w_grn = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (r_state == S_ALL_RED || r_active != DIR_W'(i)) begin
                w_red[i] = 1'b1;
            end else begin
                case (r_state)
                    S_GREEN_MIN, S_GREEN_HOLD: w_grn[i] = 1'b1;
                    S_YELLOW: begin
                        w_red[i] = 1'b1;
                        w_grn[i] = 1'b1;
                    end
                    default: w_red[i] = 1'b1;
                endcase
            end
        end
    end

    // Registered LED channels, dark until the controller is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_R <= '0;
            r_G <= '0;
            r_B <= '0;
        end else if (r_start) begin
            r_R <= w_red;
            r_G <= w_grn;
            r_B <= r_pending;
        end else begin
            r_R <= '0;
            r_G <= '0;
            r_B <= '0;
        end
    end

`ifdef TRAFFIC_LIGHT_PWM_EN
    localparam int           HALF_CNT = (TICK / 2 > 0) ? TICK / 2 : 1;
    localparam logic [PW-1:0] HALF_M1 = PW'(HALF_CNT - 1);

    logic r_phase;

    // 1 kHz dimming phase: toggles at mid-period and at wrap of the prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_phase <= 1'b0;
        else if (r_start && (r_presc == HALF_M1 || r_presc == PRESC_MAX))
            r_phase <= ~r_phase;
    end

    assign R = r_R & {NUM_DIR{r_phase}};
    assign G = r_G & {NUM_DIR{r_phase}};
    assign B = r_B & {NUM_DIR{r_phase}};
`else
    assign R = r_R;
    assign G = r_G;
    assign B = r_B;
`endif

    assign active_dir = r_active;

endmodule
